// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase enum and direction encoding for the intersection
// controller and the downstream lamp driver.
package traffic_pkg;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_WALK   = 2'd3
  } phase_e;

endpackage

// File: rtl/traffic_dwell_timer.sv
// Tick-driven dwell counter: clear dominates, advances on tick, optionally
// holds at SAT_MAX so a resting green never wraps.
module traffic_dwell_timer #(
  parameter logic [3:0] SAT_MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       clr_i,
  input  logic       sat_en_i,
  output logic [3:0] cnt_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = 4'd0;
    else if (tick_i && !(sat_en_i && cnt_q >= SAT_MAX))
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-road phase scheduler with actuated green, pedestrian walk and
// emergency preemption; all outputs decode from registered state.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  input  logic       emerg_ns,
  input  logic       emerg_ew,
  output logic [2:0] signal1_light,
  output logic [2:0] signal2_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [1:0] phase,
  output logic       dir
);

  localparam logic [3:0] MIN_L  = 4'(MIN_GREEN - 1);
  localparam logic [3:0] MAX_L  = 4'(MAX_GREEN - 1);
  localparam logic [3:0] YEL_L  = 4'(YELLOW_T - 1);
  localparam logic [3:0] AR_L   = 4'(ALLRED_T - 1);
  localparam logic [3:0] WALK_L = 4'(WALK_T - 1);

  phase_e     phase_q, phase_d;
  logic       dir_q, dir_d;
  logic       ped_q, ped_d;
  logic [3:0] cnt;
  logic       own_emerg, oth_emerg, any_emerg, own_car, oth_car, new_dir;

  traffic_dwell_timer #(.SAT_MAX(MAX_L)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick_i   (tick),
    .clr_i    (phase_d != phase_q),
    .sat_en_i (phase_q == PH_GREEN),
    .cnt_o    (cnt)
  );

  assign own_emerg = (dir_q == DIR_NS) ? emerg_ns : emerg_ew;
  assign oth_emerg = (dir_q == DIR_NS) ? emerg_ew : emerg_ns;
  assign any_emerg = emerg_ns | emerg_ew;
  assign own_car   = (dir_q == DIR_NS) ? ns_car : ew_car;
  assign oth_car   = (dir_q == DIR_NS) ? ew_car : ns_car;
  // NS preemption outranks EW; without preemption the roads alternate.
  assign new_dir   = emerg_ns ? DIR_NS : (emerg_ew ? DIR_EW : ~dir_q);

  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    case (phase_q)
      PH_GREEN: begin
        if (!own_emerg) begin
          if (oth_emerg)
            phase_d = PH_YELLOW;
          else if (tick && cnt >= MIN_L && (oth_car || ped_q) &&
                   (!own_car || cnt == MAX_L))
            phase_d = PH_YELLOW;
        end
      end
      PH_YELLOW: if (tick && cnt == YEL_L) phase_d = PH_ALLRED;
      PH_ALLRED: begin
        if (tick && cnt == AR_L) begin
          if (ped_q && !any_emerg) begin
            phase_d = PH_WALK;
          end else begin
            phase_d = PH_GREEN;
            dir_d   = new_dir;
          end
        end
      end
      PH_WALK: begin
        if (any_emerg || (tick && cnt == WALK_L)) begin
          phase_d = PH_GREEN;
          dir_d   = new_dir;
        end
      end
      default: phase_d = PH_GREEN;
    endcase
  end

  // Entering WALK serves the request, even against a same-cycle press.
  always_comb begin
    ped_d = ped_q;
    if (phase_d == PH_WALK && phase_q != PH_WALK)
      ped_d = 1'b0;
    else if (ped_req && phase_q != PH_WALK)
      ped_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_GREEN;
      dir_q   <= DIR_NS;
      ped_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      ped_q   <= ped_d;
    end
  end

  always_comb begin
    signal1_light = LAMP_R;
    signal2_light = LAMP_R;
    if (phase_q == PH_GREEN) begin
      if (dir_q == DIR_NS) signal1_light = LAMP_G;
      else                 signal2_light = LAMP_G;
    end else if (phase_q == PH_YELLOW) begin
      if (dir_q == DIR_NS) signal1_light = LAMP_Y;
      else                 signal2_light = LAMP_Y;
    end
  end

  assign walk        = (phase_q == PH_WALK);
  assign ped_pending = ped_q;
  assign phase       = phase_q;
  assign dir         = dir_q;

endmodule
